// File: rtl/nf_stream_arbiter_2to1_if.sv
// ---------------------------------------------------------------------------
// nf_stream_arbiter_2to1_if
//
// One AXI4-Stream link (tdata/tkeep/tuser/tlast/tvalid forward, tready back).
// The arbiter uses three of these: two upstream sources and one downstream
// sink.
//
// Handshake: a beat transfers on a rising clk edge where tvalid and tready are
// both 1. The master holds tdata/tkeep/tuser/tlast stable while tvalid is 1 and
// tready is 0, and never waits for tready before raising tvalid. tready may
// depend on tvalid, never the other way round.
//
// Modports:
//   master - drives tdata, tkeep, tuser, tlast, tvalid; receives tready
//   slave  - receives tdata, tkeep, tuser, tlast, tvalid; drives tready
// ---------------------------------------------------------------------------
interface nf_stream_arbiter_2to1_if #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128
);

  logic [C_AXIS_DATA_WIDTH-1:0]   tdata;
  logic [C_AXIS_DATA_WIDTH/8-1:0] tkeep;
  logic [C_AXIS_TUSER_WIDTH-1:0]  tuser;
  logic                           tlast;
  logic                           tvalid;
  logic                           tready;

  modport master (
    output tdata,
    output tkeep,
    output tuser,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tuser,
    input  tlast,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/nf_stream_arbiter_2to1.sv
// ---------------------------------------------------------------------------
// nf_stream_arbiter_2to1
//
// Packet-level round-robin arbiter that merges two AXI4-Stream sources onto
// one stream. A grant is held from a packet's first beat until its tlast beat
// transfers, so packets never interleave. The datapath is a pure
// combinational mux: the granted source's beat appears on m_axis in the same
// cycle and the downstream tready is routed straight back to it.
//
// Ports:
//   clk        in   single clock
//   reset      in   asynchronous, active-high reset
//   s0_axis    slave  source 0 stream (tready driven here)
//   s1_axis    slave  source 1 stream (tready driven here)
//   m_axis     master arbitrated stream (tready from downstream)
//   cnt_clear  in   synchronous clear of both packet counters
//   grant      out  one-hot owner: 01 = port 0, 10 = port 1, 00 = idle
//   pkt_cnt0   out  packets completed from port 0 (wraps)
//   pkt_cnt1   out  packets completed from port 1 (wraps)
//   state_dbg  out  raw FSM state encoding (IDLE=0, GRANT0=1, GRANT1=2)
// ---------------------------------------------------------------------------
module nf_stream_arbiter_2to1 #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128
) (
  input  logic                            clk,
  input  logic                            reset,
  nf_stream_arbiter_2to1_if.slave         s0_axis,
  nf_stream_arbiter_2to1_if.slave         s1_axis,
  nf_stream_arbiter_2to1_if.master        m_axis,
  input  logic                            cnt_clear,
  output logic [1:0]                      grant,
  output logic [31:0]                     pkt_cnt0,
  output logic [31:0]                     pkt_cnt1,
  output logic [1:0]                      state_dbg
);

  localparam int KEEP_W = C_AXIS_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Round-robin pointer: the port that wins when both are valid in IDLE.
  // 0 = port 0 preferred, 1 = port 1 preferred.
  logic rr_ptr;
  logic rr_ptr_next;

  // Combinational datapath and handshake results.
  logic [C_AXIS_DATA_WIDTH-1:0]  mux_tdata;
  logic [KEEP_W-1:0]             mux_tkeep;
  logic [C_AXIS_TUSER_WIDTH-1:0] mux_tuser;
  logic                          mux_tlast;
  logic                          mux_tvalid;
  logic                          s0_ready;
  logic                          s1_ready;

  // One-cycle pulses: the tlast beat of a packet transfers this cycle.
  logic pkt_done0;
  logic pkt_done1;

  // -------------------------------------------------------------------------
  // State and pointer registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
    end else begin
      state  <= state_next;
      rr_ptr <= rr_ptr_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state, datapath mux and handshake routing
  //
  // m_axis.tvalid is taken from the granted source's tvalid only; it never
  // depends on m_axis.tready, so no combinational loop can form through a
  // downstream that derives tready from tvalid.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    rr_ptr_next = rr_ptr;
    mux_tdata   = '0;
    mux_tkeep   = '0;
    mux_tuser   = '0;
    mux_tlast   = 1'b0;
    mux_tvalid  = 1'b0;
    s0_ready    = 1'b0;
    s1_ready    = 1'b0;
    pkt_done0   = 1'b0;
    pkt_done1   = 1'b0;

    case (state)
      IDLE: begin
        // Arbitration decision only; nothing is passed through this cycle,
        // which is the single bubble paid when starting from idle.
        if (rr_ptr == 1'b0) begin
          if (s0_axis.tvalid) begin
            state_next = GRANT0;
          end else if (s1_axis.tvalid) begin
            state_next = GRANT1;
          end
        end else begin
          if (s1_axis.tvalid) begin
            state_next = GRANT1;
          end else if (s0_axis.tvalid) begin
            state_next = GRANT0;
          end
        end
      end

      GRANT0: begin
        mux_tdata  = s0_axis.tdata;
        mux_tkeep  = s0_axis.tkeep;
        mux_tuser  = s0_axis.tuser;
        mux_tlast  = s0_axis.tlast;
        mux_tvalid = s0_axis.tvalid;
        s0_ready   = m_axis.tready;
        if (s0_axis.tvalid && m_axis.tready && s0_axis.tlast) begin
          pkt_done0   = 1'b1;
          rr_ptr_next = 1'b1;
          // Hand straight over to a waiting port 1 with no bubble.
          state_next  = s1_axis.tvalid ? GRANT1 : IDLE;
        end
      end

      GRANT1: begin
        mux_tdata  = s1_axis.tdata;
        mux_tkeep  = s1_axis.tkeep;
        mux_tuser  = s1_axis.tuser;
        mux_tlast  = s1_axis.tlast;
        mux_tvalid = s1_axis.tvalid;
        s1_ready   = m_axis.tready;
        if (s1_axis.tvalid && m_axis.tready && s1_axis.tlast) begin
          pkt_done1   = 1'b1;
          rr_ptr_next = 1'b0;
          state_next  = s0_axis.tvalid ? GRANT0 : IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Grant decode
  // -------------------------------------------------------------------------
  always_comb begin
    grant = 2'b00;
    case (state)
      GRANT0:  grant = 2'b01;
      GRANT1:  grant = 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign state_dbg = state;

  // -------------------------------------------------------------------------
  // Output wiring
  // -------------------------------------------------------------------------
  assign m_axis.tdata   = mux_tdata;
  assign m_axis.tkeep   = mux_tkeep;
  assign m_axis.tuser   = mux_tuser;
  assign m_axis.tlast   = mux_tlast;
  assign m_axis.tvalid  = mux_tvalid;
  assign s0_axis.tready = s0_ready;
  assign s1_axis.tready = s1_ready;

  // -------------------------------------------------------------------------
  // Packet counters
  //
  // cnt_clear has priority over a coincident completion, so a clear issued
  // on a tlast cycle leaves the counter at zero. Counters wrap naturally.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_cnt0 <= 32'd0;
      pkt_cnt1 <= 32'd0;
    end else if (cnt_clear) begin
      pkt_cnt0 <= 32'd0;
      pkt_cnt1 <= 32'd0;
    end else begin
      if (pkt_done0) begin
        pkt_cnt0 <= pkt_cnt0 + 32'd1;
      end
      if (pkt_done1) begin
        pkt_cnt1 <= pkt_cnt1 + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_nf_stream_arbiter_2to1.sv
// ---------------------------------------------------------------------------
// tb_nf_stream_arbiter_2to1
//
// Inputs are driven 1 ns after the rising edge; outputs are sampled on the
// falling edge. A table of single-cycle vectors covers the arbitration rules
// cycle by cycle, followed by packet-level sequences checked against an
// expected-beat queue.
// ---------------------------------------------------------------------------
module tb_nf_stream_arbiter_2to1;

  localparam int DW     = 256;
  localparam int UW     = 128;
  localparam int KW     = DW / 8;
  localparam int WORD_W = KW + UW + DW;
  localparam int REC_W  = 2 + 1 + WORD_W;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic reset;
  logic cnt_clear;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  nf_stream_arbiter_2to1_if #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW)) s0_if ();
  nf_stream_arbiter_2to1_if #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW)) s1_if ();
  nf_stream_arbiter_2to1_if #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW)) m_if ();

  logic [1:0]  grant;
  logic [31:0] pkt_cnt0;
  logic [31:0] pkt_cnt1;
  logic [1:0]  state_dbg;

  nf_stream_arbiter_2to1 #(
    .C_AXIS_DATA_WIDTH (DW),
    .C_AXIS_TUSER_WIDTH(UW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s0_axis   (s0_if),
    .s1_axis   (s1_if),
    .m_axis    (m_if),
    .cnt_clear (cnt_clear),
    .grant     (grant),
    .pkt_cnt0  (pkt_cnt0),
    .pkt_cnt1  (pkt_cnt1),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  function automatic logic [WORD_W-1:0] make_word(input int port, input int pkt, input int beat);
    logic [31:0] tag;
    tag = {8'hA0 | 8'(port), 8'(pkt), 16'(beat)};
    return {tag, {4{~tag}}, {8{tag}}};
  endfunction

  task automatic set_src(input int port, input logic v, input logic l, input logic [WORD_W-1:0] w);
    if (port == 0) begin
      s0_if.tvalid = v;
      s0_if.tlast  = l;
      {s0_if.tkeep, s0_if.tuser, s0_if.tdata} = w;
    end else begin
      s1_if.tvalid = v;
      s1_if.tlast  = l;
      {s1_if.tkeep, s1_if.tuser, s1_if.tdata} = w;
    end
  endtask

  function automatic logic get_ready(input int port);
    return (port == 0) ? s0_if.tready : s1_if.tready;
  endfunction

  task automatic reset_dut();
    reset     = 1'b1;
    cnt_clear = 1'b0;
    m_if.tready = 1'b1;
    set_src(0, 1'b0, 1'b0, '0);
    set_src(1, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Sends one packet; gap_beat > 0 drops tvalid for two cycles before that beat.
  task automatic send_pkt(input int port, input int pkt, input int nbeats, input int gap_beat);
    for (int b = 0; b < nbeats; b++) begin
      if (b == gap_beat && b > 0) begin
        set_src(port, 1'b0, 1'b0, '0);
        for (int g = 0; g < 2; g++) begin
          @(negedge clk);
          chk($sformatf("gap_grant_p%0d_c%0d", port, g), 64'(grant),
              (port == 0) ? 64'h1 : 64'h2);
          @(posedge clk);
          #1;
        end
      end
      set_src(port, 1'b1, (b == nbeats - 1), make_word(port, pkt, b));
      for (int k = 0; ; k++) begin
        @(negedge clk);
        if (get_ready(port)) break;
        if (k > 500) begin
          errors++;
          $display("FAIL send_timeout: port %0d pkt %0d beat %0d never accepted", port, pkt, b);
          break;
        end
      end
      @(posedge clk);
      #1;
    end
    set_src(port, 1'b0, 1'b0, '0);
  endtask

  // ---------------------------------------------------------------- scoreboard
  logic [REC_W-1:0] exp_q[$];
  logic mon_en = 1'b0;
  logic bp_en  = 1'b0;
  logic have_first;
  int   first_cyc;
  int   last_cyc;

  task automatic push_exp(input int port, input int pkt, input int beat, input logic last);
    exp_q.push_back({(port == 0) ? 2'b01 : 2'b10, last, make_word(port, pkt, beat)});
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (grant == 2'b01) begin
        chk("idle_port1_ready_low", 64'(s1_if.tready), 64'h0);
      end
      if (grant == 2'b10) begin
        chk("idle_port0_ready_low", 64'(s0_if.tready), 64'h0);
      end
      if (m_if.tvalid && m_if.tready) begin
        logic [REC_W-1:0] act;
        logic [REC_W-1:0] exp;
        act = {grant, m_if.tlast, m_if.tkeep, m_if.tuser, m_if.tdata};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: grant %b tag %h", grant, m_if.tdata[31:0]);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin
            errors++;
            $display("FAIL beat_compare: got grant %b last %b tag %h, expected grant %b last %b tag %h",
                     act[REC_W-1 -: 2], act[REC_W-3], act[31:0],
                     exp[REC_W-1 -: 2], exp[REC_W-3], exp[31:0]);
          end
        end
        if (!have_first) begin
          first_cyc  = cyc;
          have_first = 1'b1;
        end
        last_cyc = cyc;
      end
    end
  end

  always @(posedge clk) begin
    if (bp_en) begin
      #1 m_if.tready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic        v0, l0, v1, l1, mr, clr;
    logic [1:0]  grant;
    logic        s0r, s1r, mv, ml;
    int          src;     // 0 none, 1 port 0, 2 port 1
    logic [31:0] c0, c1;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           v0 l0 v1 l1 mr clr grant  s0r s1r mv ml src c0 c1
    vecs[0]  = '{0, 0, 0, 0, 1, 0, 2'b00, 0,  0,  0, 0, 0,  0, 0};
    vecs[1]  = '{0, 0, 1, 0, 1, 0, 2'b00, 0,  0,  0, 0, 0,  0, 0};
    vecs[2]  = '{1, 0, 1, 0, 1, 0, 2'b10, 0,  1,  1, 0, 2,  0, 0};
    vecs[3]  = '{1, 0, 1, 1, 0, 0, 2'b10, 0,  0,  1, 1, 2,  0, 0};
    vecs[4]  = '{1, 0, 1, 1, 1, 0, 2'b10, 0,  1,  1, 1, 2,  0, 0};
    vecs[5]  = '{1, 1, 0, 0, 1, 0, 2'b01, 1,  0,  1, 1, 1,  0, 1};
    vecs[6]  = '{1, 0, 0, 0, 1, 0, 2'b00, 0,  0,  0, 0, 0,  1, 1};
    vecs[7]  = '{0, 0, 1, 0, 1, 0, 2'b01, 1,  0,  0, 0, 1,  1, 1};
    vecs[8]  = '{1, 1, 1, 0, 1, 1, 2'b01, 1,  0,  1, 1, 1,  1, 1};
    vecs[9]  = '{0, 0, 1, 1, 1, 0, 2'b10, 0,  1,  1, 1, 2,  0, 0};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 2'b00, 0,  0,  0, 0, 0,  0, 1};

    // ------------------------------------------------ reset values
    reset_dut();
    @(negedge clk);
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_mvalid", 64'(m_if.tvalid), 64'h0);
    chk("rst_cnt0", 64'(pkt_cnt0), 64'h0);
    chk("rst_cnt1", 64'(pkt_cnt1), 64'h0);
    @(posedge clk);
    #1;

    // ------------------------------------------------ table vectors
    for (int i = 0; i < 11; i++) begin
      logic [WORD_W-1:0] w0;
      logic [WORD_W-1:0] w1;
      logic [WORD_W-1:0] wexp;
      w0 = make_word(0, i, 0);
      w1 = make_word(1, i, 0);
      set_src(0, vecs[i].v0, vecs[i].l0, w0);
      set_src(1, vecs[i].v1, vecs[i].l1, w1);
      m_if.tready = vecs[i].mr;
      cnt_clear   = vecs[i].clr;
      @(negedge clk);
      chk($sformatf("row%0d_grant", i), 64'(grant), 64'(vecs[i].grant));
      chk($sformatf("row%0d_s0_ready", i), 64'(s0_if.tready), 64'(vecs[i].s0r));
      chk($sformatf("row%0d_s1_ready", i), 64'(s1_if.tready), 64'(vecs[i].s1r));
      chk($sformatf("row%0d_m_valid", i), 64'(m_if.tvalid), 64'(vecs[i].mv));
      chk($sformatf("row%0d_cnt0", i), 64'(pkt_cnt0), 64'(vecs[i].c0));
      chk($sformatf("row%0d_cnt1", i), 64'(pkt_cnt1), 64'(vecs[i].c1));
      if (vecs[i].src != 0) begin
        wexp = (vecs[i].src == 1) ? w0 : w1;
        chk($sformatf("row%0d_m_last", i), 64'(m_if.tlast), 64'(vecs[i].ml));
        chk($sformatf("row%0d_m_word", i),
            64'({m_if.tkeep, m_if.tuser, m_if.tdata} == wexp), 64'h1);
      end
      @(posedge clk);
      #1;
    end
    cnt_clear   = 1'b0;
    m_if.tready = 1'b1;

    // ------------------------------------------------ reset mid-packet
    reset_dut();
    set_src(0, 1'b1, 1'b1, make_word(0, 0, 0));
    @(posedge clk); #1;                          // IDLE -> GRANT0
    @(posedge clk); #1;                          // tlast: rr -> 1, cnt0 = 1
    set_src(0, 1'b1, 1'b0, make_word(0, 1, 0));
    set_src(1, 1'b1, 1'b0, make_word(1, 1, 0));
    @(posedge clk); #1;                          // rr prefers port 1
    @(negedge clk);
    chk("pre_rst_grant", 64'(grant), 64'h2);
    chk("pre_rst_cnt0", 64'(pkt_cnt0), 64'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_grant", 64'(grant), 64'h0);
    chk("mid_rst_s0_ready", 64'(s0_if.tready), 64'h0);
    chk("mid_rst_s1_ready", 64'(s1_if.tready), 64'h0);
    chk("mid_rst_m_valid", 64'(m_if.tvalid), 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_grant_idle", 64'(grant), 64'h0);
    chk("post_rst_cnt0", 64'(pkt_cnt0), 64'h0);
    chk("post_rst_cnt1", 64'(pkt_cnt1), 64'h0);
    @(negedge clk);
    chk("post_rst_first_grant", 64'(grant), 64'h1);
    @(posedge clk); #1;

    // ------------------------------------------------ single source
    reset_dut();
    for (int p = 0; p < 3; p++)
      for (int b = 0; b < 3; b++) push_exp(0, p, b, b == 2);
    have_first = 1'b0;
    mon_en = 1'b1;
    begin
      int t0;
      t0 = cyc;
      for (int p = 0; p < 3; p++) send_pkt(0, p, 3, -1);
      chk("single_first_latency", 64'(first_cyc - t0), 64'h1);
    end
    chk("single_cnt0", 64'(pkt_cnt0), 64'h3);
    chk("single_q_empty", 64'(exp_q.size()), 64'h0);

    // ------------------------------------------------ contention
    reset_dut();
    for (int p = 0; p < 4; p++) begin
      for (int b = 0; b < 2; b++) push_exp(0, p, b, b == 1);
      for (int b = 0; b < 2; b++) push_exp(1, p, b, b == 1);
    end
    have_first = 1'b0;
    fork
      begin
        for (int p = 0; p < 4; p++) send_pkt(0, p, 2, -1);
      end
      begin
        for (int p = 0; p < 4; p++) send_pkt(1, p, 2, -1);
      end
    join
    chk("cont_span", 64'(last_cyc - first_cyc), 64'd15);
    chk("cont_cnt0", 64'(pkt_cnt0), 64'h4);
    chk("cont_cnt1", 64'(pkt_cnt1), 64'h4);
    chk("cont_q_empty", 64'(exp_q.size()), 64'h0);

    // ------------------------------------------------ backpressure and gaps
    reset_dut();
    for (int b = 0; b < 4; b++) push_exp(0, 7, b, b == 3);
    for (int b = 0; b < 2; b++) push_exp(1, 8, b, b == 1);
    bp_en = 1'b1;
    fork
      send_pkt(0, 7, 4, 2);
      send_pkt(1, 8, 2, -1);
    join
    bp_en = 1'b0;
    @(posedge clk); #1;
    m_if.tready = 1'b1;
    chk("bp_cnt0", 64'(pkt_cnt0), 64'h1);
    chk("bp_cnt1", 64'(pkt_cnt1), 64'h1);
    chk("bp_q_empty", 64'(exp_q.size()), 64'h0);

    // ------------------------------------------------ single-beat packets
    reset_dut();
    for (int p = 0; p < 4; p++) begin
      push_exp(0, p, 0, 1'b1);
      push_exp(1, p, 0, 1'b1);
    end
    have_first = 1'b0;
    fork
      begin
        for (int p = 0; p < 4; p++) send_pkt(0, p, 1, -1);
      end
      begin
        for (int p = 0; p < 4; p++) send_pkt(1, p, 1, -1);
      end
    join
    chk("sb_span", 64'(last_cyc - first_cyc), 64'd7);
    chk("sb_cnt0", 64'(pkt_cnt0), 64'h4);
    chk("sb_cnt1", 64'(pkt_cnt1), 64'h4);
    chk("sb_q_empty", 64'(exp_q.size()), 64'h0);

    // ------------------------------------------------ counter wrap and clear
    reset_dut();
    push_exp(0, 20, 0, 1'b1);
    send_pkt(0, 20, 1, -1);
    chk("wrap_pre_cnt0", 64'(pkt_cnt0), 64'h1);
    force dut.pkt_cnt1 = 32'hFFFF_FFFF;
    #1;
    release dut.pkt_cnt1;
    @(negedge clk);
    chk("wrap_forced_cnt1", 64'(pkt_cnt1), 64'hFFFF_FFFF);
    @(posedge clk); #1;
    push_exp(1, 21, 0, 1'b1);
    push_exp(1, 21, 1, 1'b1 ^ 1'b1);
    exp_q.delete(exp_q.size() - 1);
    send_pkt(1, 21, 1, -1);
    chk("wrap_cnt1", 64'(pkt_cnt1), 64'h0);
    chk("wrap_cnt0_kept", 64'(pkt_cnt0), 64'h1);
    push_exp(0, 22, 0, 1'b1);
    set_src(0, 1'b1, 1'b1, make_word(0, 22, 0));
    @(posedge clk); #1;                          // IDLE -> GRANT0
    cnt_clear = 1'b1;
    @(negedge clk);
    chk("clr_grant", 64'(grant), 64'h1);
    chk("clr_pre_cnt0", 64'(pkt_cnt0), 64'h1);
    @(posedge clk); #1;                          // tlast and clear together
    cnt_clear = 1'b0;
    set_src(0, 1'b0, 1'b0, '0);
    @(negedge clk);
    chk("clr_cnt0", 64'(pkt_cnt0), 64'h0);
    chk("clr_grant_idle", 64'(grant), 64'h0);
    chk("clr_q_empty", 64'(exp_q.size()), 64'h0);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
